// File: rtl/gpu_dispatcher_if.sv
// Dispatcher-side bundle: kernel launch from the DCR plus per-core run/retire handshakes.
// The slave modport is the dispatcher; the master modport is the DCR/core side.
interface gpu_dispatcher_if #(
    parameter int unsigned NUM_CORES         = 2,
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned TC_W              = 8
);
    localparam int unsigned CNT_W = $clog2(THREADS_PER_BLOCK + 1);

    logic                        start;
    logic [TC_W-1:0]             thread_count;
    logic [NUM_CORES-1:0]        core_done;
    logic [NUM_CORES-1:0]        core_start;
    logic [NUM_CORES-1:0]        core_reset;
    logic [NUM_CORES*TC_W-1:0]   core_block_id;
    logic [NUM_CORES*CNT_W-1:0]  core_thread_count;
    logic                        done;

    modport master (
        output start, thread_count, core_done,
        input  core_start, core_reset, core_block_id, core_thread_count, done
    );

    modport slave (
        input  start, thread_count, core_done,
        output core_start, core_reset, core_block_id, core_thread_count, done
    );
endinterface

// File: rtl/gpu_dispatcher.sv
// Block dispatcher: splits a kernel's thread count into fixed-size blocks, hands them to
// free cores one per cycle, pulses each core's reset on completion and flags kernel done.
module gpu_dispatcher #(
    parameter int unsigned NUM_CORES         = 2,
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned TC_W              = 8
) (
    input  logic            clk,
    input  logic            reset,
    gpu_dispatcher_if.slave bus
);
    localparam int unsigned LOG2_TPB = $clog2(THREADS_PER_BLOCK);
    localparam int unsigned CNT_W    = $clog2(THREADS_PER_BLOCK + 1);
    // One extra bit so ceil(TC/TPB) cannot overflow at the top of the thread-count range
    localparam int unsigned BLK_W    = TC_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DONE} state_t;
    typedef enum logic [1:0] {C_FREE, C_BUSY, C_RESET} core_state_t;

    state_t          state;
    core_state_t     core_st [NUM_CORES];
    logic [TC_W-1:0] tc;
    logic [BLK_W-1:0] total_blocks;
    logic [BLK_W-1:0] blocks_dispatched;
    logic [BLK_W-1:0] blocks_done;

    logic                 can_dispatch_c;
    logic                 found_c;
    logic [NUM_CORES-1:0] dispatch_sel_c;
    logic [NUM_CORES-1:0] retire_c;
    logic [BLK_W-1:0]     retire_cnt_c;
    logic [BLK_W-1:0]     remaining_c;
    logic [CNT_W-1:0]     block_threads_c;

    // Lowest free core gets the next block; every busy core seeing core_done retires.
    always_comb begin
        can_dispatch_c = (state == S_DISPATCH) && (blocks_dispatched < total_blocks);
        found_c        = 1'b0;
        dispatch_sel_c = '0;
        retire_c       = '0;
        retire_cnt_c   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (can_dispatch_c && !found_c && core_st[i] == C_FREE) begin
                dispatch_sel_c[i] = 1'b1;
                found_c           = 1'b1;
            end
            retire_c[i]  = (core_st[i] == C_BUSY) && bus.core_done[i];
            retire_cnt_c = retire_cnt_c + BLK_W'(retire_c[i]);
        end
        remaining_c     = BLK_W'(tc) - (blocks_dispatched << LOG2_TPB);
        block_threads_c = (remaining_c >= BLK_W'(THREADS_PER_BLOCK)) ?
                          CNT_W'(THREADS_PER_BLOCK) : CNT_W'(remaining_c);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= S_IDLE;
            tc                    <= '0;
            total_blocks          <= '0;
            blocks_dispatched     <= '0;
            blocks_done           <= '0;
            bus.done              <= 1'b0;
            bus.core_start        <= '0;
            bus.core_reset        <= '0;
            bus.core_block_id     <= '0;
            bus.core_thread_count <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                core_st[i] <= C_FREE;
            end
        end else begin
            // Per-core lifecycle: FREE -> BUSY -> RESET (one-cycle pulse) -> FREE
            for (int i = 0; i < NUM_CORES; i++) begin
                case (core_st[i])
                    C_FREE: begin
                        if (dispatch_sel_c[i]) begin
                            core_st[i]                                <= C_BUSY;
                            bus.core_start[i]                         <= 1'b1;
                            bus.core_block_id[i*TC_W +: TC_W]         <= TC_W'(blocks_dispatched);
                            bus.core_thread_count[i*CNT_W +: CNT_W]   <= block_threads_c;
                        end
                    end
                    C_BUSY: begin
                        if (retire_c[i]) begin
                            core_st[i]        <= C_RESET;
                            bus.core_start[i] <= 1'b0;
                            bus.core_reset[i] <= 1'b1;
                        end
                    end
                    C_RESET: begin
                        core_st[i]        <= C_FREE;
                        bus.core_reset[i] <= 1'b0;
                    end
                    default: core_st[i] <= C_FREE;
                endcase
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state             <= S_DISPATCH;
                        tc                <= bus.thread_count;
                        total_blocks      <= (BLK_W'(bus.thread_count) +
                                              BLK_W'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB;
                        blocks_dispatched <= '0;
                        blocks_done       <= '0;
                        bus.done          <= 1'b0;
                    end
                end
                S_DISPATCH: begin
                    if (dispatch_sel_c != '0) begin
                        blocks_dispatched <= blocks_dispatched + BLK_W'(1);
                    end
                    blocks_done <= blocks_done + retire_cnt_c;
                    if (blocks_done == total_blocks) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/gpu_dispatcher.md
# gpu_dispatcher

Block dispatcher for the miniGPU. Sits between the device control register (DCR) and the compute cores. On `start` it takes the programmed thread count and splits it into blocks of `THREADS_PER_BLOCK` threads. It then hands blocks to free cores one at a time, resets each core after it finishes, and raises `done` once every block has retired.

## Interface
- `NUM_CORES`, 2: number of compute cores served.
- `THREADS_PER_BLOCK`, 4: threads per block; power of two, ≥ 2.
- `TC_W`, 8: width of the thread count and block ID.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  kernel launch request, sampled only in IDLE/DONE.
- `thread_count`  in  TC_W  total threads, driven from the DCR; latched on accepted `start`.
- `core_done`  in  NUM_CORES  per-core completion, level; honoured only while that core is BUSY.
- `core_start`  out  NUM_CORES  per-core run enable, held high while the core is BUSY.
- `core_reset`  out  NUM_CORES  per-core one-cycle clear pulse after completion.
- `core_block_id`  out  NUM_CORES*TC_W  block index per core, core i at bits [i*TC_W +: TC_W].
- `core_thread_count`  out  NUM_CORES*$clog2(THREADS_PER_BLOCK+1)  active threads in the assigned block.
- `done`  out  1  kernel complete, held high.

## Operation
- Top FSM has three states: IDLE, DISPATCH, DONE.
- IDLE/DONE with `start`=1:
  - latch `thread_count` as TC;
  - compute total_blocks = ceil(TC / THREADS_PER_BLOCK) = (TC + THREADS_PER_BLOCK-1) >> log2, evaluated at TC_W+1 bits so there is no overflow at TC=255;
  - clear blocks_dispatched, blocks_done and `done`;
  - go to DISPATCH.
- `start` is ignored in DISPATCH.
- Each core has its own state: FREE → BUSY → RESET → FREE.
- DISPATCH, dispatch rule:
  - condition: blocks_dispatched < total_blocks and at least one core is FREE;
  - choose the lowest-index FREE core;
  - set its block_id = blocks_dispatched;
  - set its thread count = min(THREADS_PER_BLOCK, TC − block_id·THREADS_PER_BLOCK);
  - raise its `core_start`, move it to BUSY, increment blocks_dispatched;
  - at most one dispatch per cycle.
- DISPATCH, completion rule (for a BUSY core with `core_done`=1):
  - drop its `core_start`;
  - pulse `core_reset` for exactly one cycle (RESET state);
  - return the core to FREE the cycle after the pulse.
  - blocks_done increases by the popcount of retiring cores, so simultaneous completions in one cycle are all counted.
- Dispatch and completion on different cores in the same cycle are both performed.
- When blocks_done == total_blocks, go to DONE and raise `done`. It stays high until an accepted `start` or reset.
- TC = 0: total_blocks = 0, so the FSM goes straight to DONE. No core is started.
- `core_block_id` and `core_thread_count` hold their values until the next assignment to that core.
- Reset (any time, including mid-kernel):
  - all outputs go to 0, all cores to FREE, FSM to IDLE, counters to 0;
  - in-flight blocks are abandoned;
  - `core_done` arriving after reset is ignored.

## Timing
- Accepted `start` at edge N: DISPATCH from N.
- First `core_start` rises at N+1. Each further core starts one cycle later (N+2, ...).
- `core_done` sampled high at edge M:
  - `core_start` low from M;
  - `core_reset` high from M to M+1;
  - the core is FREE at M+1 and can be redispatched at M+2.
- The last completion at edge M raises `done` at M+1.
- Minimum kernel with one block and `core_done` returned one cycle after `core_start`: `start` to `done` = 4 cycles.

## Test plan
- TC=4, NUM_CORES=2, core 0 answers `core_done` after 5 cycles → only core 0 starts, with block_id 0 and thread count 4; one `core_reset` pulse on core 0; `done` rises exactly one cycle after the pulse edge.
- TC=10 → 3 blocks with (block_id, count) = (0,4), (1,4), (2,2). Core 0 gets block 0, core 1 gets block 1 a cycle later. Block 2 goes to whichever core frees first. `done` only after all three complete.
- TC=0 → `done` one cycle after `start`; `core_start` and `core_reset` stay 0 throughout.
- TC=8, both cores assert `core_done` in the same cycle → both `core_reset` pulse together, blocks_done jumps by 2, `done` next cycle.
- `start` pulsed again mid-DISPATCH with a different `thread_count` → ignored; the original block sequence and counts are unchanged.
- `reset` driven low while two cores are BUSY → all outputs 0 immediately (asynchronously). After release, with `core_done` still high: no `core_reset` pulse and `done` stays 0 until a new `start`.
